// File: rtl/instruction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared types for the instruction encode/decode path:
//   instruction_t  - decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7)
//   alu_ops        - ALU operation enum shared with the execute stage
//   instr_fmt_t    - RV32I encoding format tag (R, I, S, B, U, J)
//   enc_state_t    - encoder control states
//   OPC_*          - RV32I base opcodes
//   fits_signed()  - immediate range helper (is v a sign-extension from bit msb?)
// -----------------------------------------------------------------------------
package instruction_encoder_pkg;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } instruction_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_ops;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } instr_fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_ACTIVE, ST_FULL
  } enc_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // True when bits [31:msb] of v are all zero or all one, i.e. v is the
  // sign-extension of v[msb:0].
  function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
    logic [31:0] mask;
    logic [31:0] upper;
    mask  = 32'hFFFF_FFFF << msb;
    upper = v & mask;
    return (upper == 32'h0000_0000) || (upper == mask);
  endfunction

endpackage

// File: rtl/instruction_encoder_imm_pack.sv
// -----------------------------------------------------------------------------
// imm_pack
// Combinational RV32I field packer. Scatters the decoded fields and the
// immediate into a 32-bit instruction word according to the format tag and
// flags immediates that do not fit the chosen format (the truncated word is
// still produced).
// Ports:
//   fmt_i        format tag
//   instr_i      decoded fields
//   imm_i        immediate (signed byte offset or value)
//   word_o       packed instruction word
//   range_err_o  immediate out of range for fmt_i
// -----------------------------------------------------------------------------
module imm_pack
  import instruction_encoder_pkg::*;
(
  input  instr_fmt_t   fmt_i,
  input  instruction_t instr_i,
  input  logic [31:0]  imm_i,
  output logic [31:0]  word_o,
  output logic         range_err_o
);

  // Format-dependent bit scatter and range check.
  always_comb begin
    word_o      = 32'h0000_0000;
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o      = {instr_i.funct7, instr_i.rs2, instr_i.rs1, instr_i.funct3,
                       instr_i.rd, instr_i.opcode};
        range_err_o = 1'b0;
      end
      FMT_I: begin
        word_o      = {imm_i[11:0], instr_i.rs1, instr_i.funct3, instr_i.rd,
                       instr_i.opcode};
        range_err_o = !fits_signed(imm_i, 5'd11);
      end
      FMT_S: begin
        word_o      = {imm_i[11:5], instr_i.rs2, instr_i.rs1, instr_i.funct3,
                       imm_i[4:0], instr_i.opcode};
        range_err_o = !fits_signed(imm_i, 5'd11);
      end
      FMT_B: begin
        word_o      = {imm_i[12], imm_i[10:5], instr_i.rs2, instr_i.rs1,
                       instr_i.funct3, imm_i[4:1], imm_i[11], instr_i.opcode};
        range_err_o = !fits_signed(imm_i, 5'd12) || imm_i[0];
      end
      FMT_U: begin
        word_o      = {imm_i[31:12], instr_i.rd, instr_i.opcode};
        range_err_o = (imm_i[11:0] != 12'h000);
      end
      FMT_J: begin
        word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       instr_i.rd, instr_i.opcode};
        range_err_o = !fits_signed(imm_i, 5'd20) || imm_i[0];
      end
      default: begin
        word_o      = 32'h0000_0000;
        range_err_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Accepts decoded instruction fields over valid/ready, packs them into RV32I
// words and writes them to consecutive imem word addresses from start_addr.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, start_addr    arm the block and load the write pointer
//   in_valid/in_ready    request handshake; in_instr, in_imm, in_fmt payload
//   mem_valid/mem_ready  imem write handshake; mem_addr, mem_wdata payload
//   count                words accepted by imem since start
//   full                 last imem address has been written
//   imm_err, err_addr    sticky range error and address of first offender
// -----------------------------------------------------------------------------
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instruction_t          in_instr,
  input  logic [31:0]           in_imm,
  input  instr_fmt_t            in_fmt,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  imm_err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  enc_state_t            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
  // Set once the last address has been loaded, so the pointer never wraps
  // onto words written earlier in the same pass.
  logic                  ptr_done_q,  ptr_done_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH:0]   count_q,     count_d;
  logic                  full_q,      full_d;
  logic                  imm_err_q,   imm_err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q,  err_addr_d;

  logic [31:0] word_s;
  logic        range_err_s;
  logic        accept_s;
  logic        mem_fire_s;

  imm_pack u_imm_pack (
    .fmt_i       (in_fmt),
    .instr_i     (in_instr),
    .imm_i       (in_imm),
    .word_o      (word_s),
    .range_err_o (range_err_s)
  );

  assign in_ready   = (state_q == ST_ACTIVE) && !start && !ptr_done_q &&
                      (!mem_valid_q || mem_ready);
  assign accept_s   = in_valid && in_ready;
  assign mem_fire_s = mem_valid_q && mem_ready;

  // Next-state computation for the control FSM, pointer and output register.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ptr_done_d  = ptr_done_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    full_d      = full_q;
    imm_err_d   = imm_err_q;
    err_addr_d  = err_addr_q;
    if (start) begin
      // start wins in every state and discards any pending word
      state_d     = ST_ACTIVE;
      ptr_d       = start_addr;
      ptr_done_d  = 1'b0;
      mem_valid_d = 1'b0;
      count_d     = '0;
      full_d      = 1'b0;
      imm_err_d   = 1'b0;
      err_addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (mem_fire_s) begin
            count_d     = count_q + 1'b1;
            mem_valid_d = 1'b0;
            if (mem_addr_q == LAST_ADDR) begin
              state_d = ST_FULL;
              full_d  = 1'b1;
            end else begin
              state_d = ST_ACTIVE;
            end
          end else begin
            count_d = count_q;
          end
          if (accept_s) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = word_s;
            ptr_d       = ptr_q + 1'b1;
            ptr_done_d  = (ptr_q == LAST_ADDR);
            if (range_err_s) begin
              imm_err_d = 1'b1;
              // only the first offender is remembered
              if (!imm_err_q) begin
                err_addr_d = ptr_q;
              end else begin
                err_addr_d = err_addr_q;
              end
            end else begin
              imm_err_d = imm_err_q;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_FULL: begin
          state_d = ST_FULL;
        end
        default: begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      ptr_done_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      imm_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ptr_done_q  <= ptr_done_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      full_q      <= full_d;
      imm_err_q   <= imm_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = full_q;
  assign imm_err   = imm_err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Encode-side counterpart of the instruction decoder. It accepts decoded instruction fields, an immediate and a format tag over a valid/ready handshake. It packs them into a 32-bit RV32I instruction word and writes the words to consecutive instruction-memory addresses. The testbench and boot loader use it to build programs in imem from field-level descriptions, which the fetch/decode path then reads back.

## Interface
Parameters:
- `WIDTH`, 32, instruction word width; only 32 is supported.
- `ADDR_WIDTH`, 10, imem word-address width; depth is 2**ADDR_WIDTH.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse: load the write pointer and arm the block.
- `start_addr`  in  ADDR_WIDTH  first word address to write.
- `in_valid`  in  1  the request fields are valid.
- `in_ready`  out  1  the block accepts the request this cycle.
- `in_instr`  in  instruction_t  opcode, rd, rs1, rs2, funct3, funct7.
- `in_imm`  in  32  immediate as a signed byte offset or value.
- `in_fmt`  in  instr_fmt_t  format tag: R, I, S, B, U or J.
- `mem_valid`  out  1  a write request is pending.
- `mem_ready`  in  1  imem accepts the write.
- `mem_addr`  out  ADDR_WIDTH  write address.
- `mem_wdata`  out  WIDTH  encoded word.
- `count`  out  ADDR_WIDTH+1  number of words accepted by imem since `start`.
- `full`  out  1  the last address has been written.
- `imm_err`  out  1  sticky flag: an immediate was out of range.
- `err_addr`  out  ADDR_WIDTH  address of the first offending word.

## Operation
- States are IDLE, ACTIVE and FULL. Reset puts the block in IDLE with every output 0.
- IDLE: `in_ready`=0. `start` moves the block to ACTIVE, sets ptr=`start_addr`, sets `count`=0 and clears `imm_err` and `err_addr`.
- ACTIVE: there is a single output register (`mem_valid`/`mem_addr`/`mem_wdata`).
  - `in_ready` = !`mem_valid` || `mem_ready`.
  - On accept, the register loads the encoded word at ptr, and ptr increments.
- Field packing by `in_fmt`. The opcode always goes to [6:0].
  - R: funct7 | rs2 | rs1 | funct3 | rd.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Range checks. Any violation still writes the truncated word.
  - I/S: imm must be the sign-extension of imm[11:0].
  - B: imm must be the sign-extension of imm[12:0], and imm[0]=0.
  - J: imm must be the sign-extension of imm[20:0], and imm[0]=0.
  - U: imm[11:0] must be 0.
  - R: imm is ignored.
- On a violation, set `imm_err`. The first violation also latches `err_addr`; later violations do not update it.
- Each imem handshake (`mem_valid`&&`mem_ready`) increments `count`.
- ACTIVE moves to FULL when imem accepts address 2**ADDR_WIDTH-1. In FULL, `in_ready`=0 and `full`=1. Only `start` leaves FULL.
- `start` has priority in every state.
  - Any unaccepted output word is discarded: `mem_valid`=0 next cycle.
  - `in_ready` is forced to 0 in the `start` cycle, so a simultaneous `in_valid` is not accepted.
  - `full` is cleared.
- `rst_n` low mid-transfer drops the pending word and returns the block to IDLE. `count`, flags and all outputs go to 0.

## Timing
- Latency: a request accepted at edge N gives `mem_valid`=1 after edge N, with the word stable until the handshake.
- Throughput is one word per cycle while `mem_ready`=1.
- `in_ready` is combinational from `mem_valid`, `mem_ready`, state and `start`. The request inputs have no combinational path to any output.
- `mem_addr`/`mem_wdata` must stay stable while `mem_valid`=1 and `mem_ready`=0.
- `count` and `full` update on the edge of the accepting handshake. `imm_err` and `err_addr` update on the input-accept edge.

## Structure
- The shared package (with `instruction_t` and `alu_ops`) gets:
  - `instr_fmt_t`, an enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
  - The opcode constants used by the bench.
- One sub-module, `imm_pack`, is combinational. It takes fmt, instr and imm and produces the word and a range_err signal. The state machine, pointer and output register live in the top level.

## Test plan
- start_addr=0; send I-type opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> `mem_wdata`=0x00500093 at `mem_addr`=0, one cycle after accept.
- S-type, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. B-type, opcode 0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3. U-type, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- I-type with imm=2048 at address 3 -> the word is still written, `imm_err`=1, `err_addr`=3. A second bad immediate at address 4 leaves `err_addr`=3.
- Hold `mem_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, word and address stable, `count` unchanged. Release -> back-to-back writes at 1 word/cycle.
- ADDR_WIDTH=2, start_addr=2; stream 3 requests -> 2 words written at addresses 2 and 3, then `full`=1, `count`=2 and the 3rd request is stalled. `start` with start_addr=0 -> the 3rd request is accepted at address 0.
- Assert `start` while a word is pending with `mem_ready`=0 -> the word is dropped, `count`=0, and the next accepted word goes to the new `start_addr`. `rst_n`=0 mid-stream -> all outputs 0 on the next edge.
